// File: rtl/edge_event_reporter_pkg.sv
// Shared edge-pipeline types: pipeline height, column width and the event record
// handed from the run tracker to the readout side.
package edge_event_reporter_pkg;
  localparam int PipelineHeight = 5;
  localparam int ColumnWidth    = 8;
  localparam int RowWidth       = $clog2(PipelineHeight);

  typedef struct packed {
    logic [RowWidth-1:0]    row;
    logic [ColumnWidth-1:0] column;
    logic [ColumnWidth-1:0] length;
  } EdgeEvent;
endpackage

// File: rtl/edge_event_reporter_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted when
// the head is popped on the same edge. DEPTH must be a power of two >= 2.
module edge_event_reporter_event_fifo
  import edge_event_reporter_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = EdgeEvent
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gate the head so an empty FIFO always presents an all-zero record.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/edge_event_reporter.sv
// Turns per-row edge runs into {row, start, length} events: run tracking and one
// pending slot per row, lowest-row-first arbitration into a FWFT event FIFO.
module edge_event_reporter
  import edge_event_reporter_pkg::*;
#(
  parameter int ROWS       = PipelineHeight,
  parameter int MIN_RUN    = 3,
  parameter int COL_W      = ColumnWidth,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hit_valid,
  input  logic [ROWS-1:0]         hit,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [$clog2(ROWS)-1:0] event_row,
  output logic [COL_W-1:0]        event_column,
  output logic [COL_W-1:0]        event_length,
  output logic                    overflow,
  output logic [7:0]              dropped_count
);
  localparam int DW = $clog2(ROWS + 1);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] run   [ROWS];
  logic [COL_W-1:0] start [ROWS];
  logic             slot_vld [ROWS];
  EdgeEvent         slot_ev  [ROWS];
  logic [ROWS-1:0]  run_end, drop, grant;

  EdgeEvent push_ev, head;
  logic     push, pop, full, empty;
  logic     can_move, found;
  logic [DW-1:0] ndrop;
  logic [8:0]    drop_sum;

  assign pop      = event_valid && event_ready;
  assign can_move = !full || pop;

  always_ff @(posedge clock) begin
    if (reset)          col <= '0;
    else if (hit_valid) col <= col + 1'b1;
  end

  always_comb begin
    grant   = '0;
    push_ev = '0;
    found   = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (can_move && slot_vld[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        push_ev  = slot_ev[i];
      end
    end
  end
  assign push = |grant;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign run_end[r] = hit_valid && !hit[r] && (run[r] >= COL_W'(MIN_RUN));
    // A slot being drained on this edge is free to take the new event.
    assign drop[r]    = run_end[r] && slot_vld[r] && !grant[r];

    always_ff @(posedge clock) begin
      if (reset) begin
        run[r]      <= '0;
        start[r]    <= '0;
        slot_vld[r] <= 1'b0;
        slot_ev[r]  <= '0;
      end else begin
        if (hit_valid) begin
          if (hit[r]) begin
            if (run[r] == '0) begin
              start[r] <= col;
              run[r]   <= COL_W'(1);
            end else if (run[r] != '1) begin
              run[r]   <= run[r] + 1'b1;
            end
          end else begin
            run[r] <= '0;
          end
        end
        if (run_end[r] && !drop[r]) begin
          slot_vld[r] <= 1'b1;
          slot_ev[r]  <= '{row: RowWidth'(r), column: start[r], length: run[r]};
        end else if (grant[r]) begin
          slot_vld[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < ROWS; i++) ndrop = ndrop + DW'(drop[i]);
    drop_sum = {1'b0, dropped_count} + 9'(ndrop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (|drop) begin
      overflow      <= 1'b1;
      dropped_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  edge_event_reporter_event_fifo #(.DEPTH(FIFO_DEPTH), .T(EdgeEvent)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign event_valid  = !empty;
  assign event_row    = head.row;
  assign event_column = head.column;
  assign event_length = head.length;
endmodule

// File: tb/tb_edge_event_reporter.sv
// Directed bench for edge_event_reporter: expected events are queued as stimulus
// is issued and a negedge monitor compares each accepted output against the queue.
module tb_edge_event_reporter;
  import edge_event_reporter_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hit_valid = 1'b0;
  logic [4:0] hit = '0;
  logic       event_ready = 1'b0;
  logic       event_valid, overflow;
  logic [2:0] event_row;
  logic [7:0] event_column, event_length, dropped_count;

  EdgeEvent exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  edge_event_reporter dut (
    .clock         (clock),
    .reset         (reset),
    .hit_valid     (hit_valid),
    .hit           (hit),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_row     (event_row),
    .event_column  (event_column),
    .event_length  (event_length),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic exp_ev(input int r, input int c, input int l);
    EdgeEvent e;
    e.row    = 3'(r);
    e.column = 8'(c);
    e.length = 8'(l);
    exp_q.push_back(e);
  endtask

  task automatic samp(input logic [4:0] h);
    hit_valid = 1'b1;
    hit = h;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    hit_valid = 1'b0;
    hit = '0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hit_valid = 1'b0;
    hit = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_valid"}, event_valid, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_dropped"}, dropped_count, 0);
    chk({tag, "_row"}, event_row, 0);
    chk({tag, "_col"}, event_column, 0);
    chk({tag, "_len"}, event_length, 0);
  endtask

  always @(negedge clock) begin
    EdgeEvent e;
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: row %0d col %0d len %0d, none expected",
                 event_row, event_column, event_length);
      end else begin
        e = exp_q.pop_front();
        chk("ev_row", event_row, e.row);
        chk("ev_col", event_column, e.column);
        chk("ev_len", event_length, e.length);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_idle_state("reset");

    // 1: row 2 run over columns 10..14, ends at 15; two-edge latency
    event_ready = 1'b1;
    repeat (10) samp(5'b00000);
    repeat (5) samp(5'b00100);
    exp_ev(2, 10, 5);
    samp(5'b00000);
    chk("t1_valid_e0", event_valid, 0);
    idle(1);
    chk("t1_valid_e1", event_valid, 1);
    idle(3);
    chk("t1_valid_after", event_valid, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: short run on row 0 (columns 16,17) is discarded
    repeat (2) samp(5'b00001);
    samp(5'b00000);
    idle(4);
    chk("t2_valid", event_valid, 0);
    chk("t2_dropped", dropped_count, 0);

    // 3: rows 1 and 3 end together; row 1 is pushed first, row 3 one cycle later
    samp(5'b00000);
    repeat (4) samp(5'b01010);
    exp_ev(1, 20, 4);
    exp_ev(3, 20, 4);
    samp(5'b00000);
    idle(1);
    chk("t3_valid_e1", event_valid, 1);
    chk("t3_row_e1", event_row, 1);
    idle(1);
    chk("t3_valid_e2", event_valid, 1);
    chk("t3_row_e2", event_row, 3);
    idle(4);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: back-pressure fills FIFO + slot, tenth run dropped, then drain
    do_reset();
    chk_idle_state("t4_reset");
    event_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat (3) samp(5'b00001);
      samp(5'b00000);
      if (k < 9) exp_ev(0, 4 * k, 3);
    end
    idle(3);
    chk("t4_valid", event_valid, 1);
    chk("t4_dropped", dropped_count, 1);
    chk("t4_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_row", event_row, 0);
      chk("t4_hold_col", event_column, 0);
      chk("t4_hold_len", event_length, 3);
      idle(1);
    end
    event_ready = 1'b1;
    idle(14);
    chk("t4_valid_drained", event_valid, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: gapped hit_valid, row 4 run across the column wrap (254,255,0,1)
    repeat (214) samp(5'b00000);
    samp(5'b10000); idle(1);
    samp(5'b10000); idle(1);
    samp(5'b10000); idle(1);
    samp(5'b10000); idle(1);
    exp_ev(4, 254, 4);
    samp(5'b00000);
    idle(1);
    exp_ev(1, 3, 3);
    repeat (3) samp(5'b00010);
    samp(5'b00000);
    idle(4);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_overflow_sticky", overflow, 1);

    // 6: reset with three queued events and row 2 mid-run
    event_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) samp(5'b00001);
      samp(5'b00000);
    end
    repeat (2) samp(5'b00100);
    idle(2);
    chk("t6_valid_pre", event_valid, 1);
    do_reset();
    chk_idle_state("t6_reset");
    event_ready = 1'b1;
    exp_ev(2, 0, 3);
    repeat (3) samp(5'b00100);
    samp(5'b00000);
    idle(4);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_valid_end", event_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/edge_event_reporter.md
Name: edge_event_reporter

Overview:
- Sits directly downstream of the edge-detection pipeline and consumes its per-row detector conclusion vector, one sample per image column.
- Tracks runs of consecutive "edge" samples on each row and discards runs shorter than MIN_RUN.
- Each qualifying run becomes an event {row, start column, length}, held in a small FIFO.
- Events leave on a valid/ready stream to the software or readout side.

Parameters:
- ROWS, 5, number of pipeline rows (equals shared PipelineHeight)
- MIN_RUN, 3, minimum run length, in valid samples, that produces an event
- COL_W, 8, width of column counter, start column and length
- FIFO_DEPTH, 8, event FIFO entries (power of two)

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- hit_valid  in  1  hit vector is a valid column sample this cycle
- hit  in  ROWS  per-row detector conclusion, bit r = row r
- event_valid  out  1  FIFO head holds an event
- event_ready  in  1  consumer accepts head this cycle
- event_row  out  $clog2(ROWS)  row index of head event
- event_column  out  COL_W  start column of head event
- event_length  out  COL_W  run length of head event
- overflow  out  1  sticky: at least one event dropped since reset
- dropped_count  out  8  dropped events, saturating at 255

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clock): clears column counter, all run counters, pending slots, FIFO, overflow and dropped_count. Outputs after the reset edge: event_valid=0, overflow=0, dropped_count=0; event_row/column/length=0.
- Reset mid-run or mid-queue discards all in-progress runs and queued events; none are reported.
- Column counter:
  - Increments by 1 on each edge with hit_valid=1 and wraps modulo 2^COL_W.
  - Holds when hit_valid=0.
  - The sample taken at an edge carries the pre-increment column value.
- Per-row run tracking (updates only when hit_valid=1):
  - Run starts on hit[r]=1 with run=0: start[r] <= column, run <= 1.
  - Run continues on hit[r]=1 with run>0: run <= run+1, saturating at 2^COL_W-1.
  - Run ends on hit[r]=0 with run>0: run <= 0. If run >= MIN_RUN, the event {r, start[r], run} is written into pending slot r.
  - No event is generated by column wrap; start is stored modulo 2^COL_W.
- Pending slots (one per row, valid bit + event):
  - If slot r is still occupied when row r ends a new qualifying run, the new event is dropped: dropped_count++ (saturating), overflow <= 1.
  - The occupied slot is retained.
- Arbiter and FIFO:
  - Fixed priority, lowest row index first. Each cycle at most one occupied slot moves into the FIFO, and that slot is cleared.
  - A move is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Simultaneous push and pop on an empty FIFO is legal; the pushed entry becomes head the next cycle.
- Output stream:
  - The FIFO is first-word-fall-through; event_valid = not empty, and the event_* fields show the head.
  - A pop occurs on an edge with event_valid && event_ready.
  - While event_valid=1 and event_ready=0, all event_* fields are held stable.
- Latency: a run ends on the sample at edge E0. Its pending slot is set at E0, the event is pushed at E1, and event_valid rises after E1. That is 2 edges when uncontended; add 1 cycle per lower-indexed row competing for the push.
- Ordering: events from one row leave in run order. Across rows, order follows push order.
- Capacity before any drop on one row: FIFO_DEPTH + 1 events (FIFO plus that row's pending slot).

Decomposition:
- Shared pipeline package holds:
  - PipelineHeight (ROWS default)
  - EdgeEvent typedef: packed struct {row, column, length}
  - ColumnWidth constant
- One sub-module, event_fifo: parameterised depth and element type EdgeEvent, FWFT, push/pop/full/empty, legal push+pop when full.
- Run tracking, pending slots and arbiter stay in edge_event_reporter.

Test Plan:
1. After reset, row 2 hit=1 on columns 10..14 (5 valid samples), then 0 at column 15 → event_valid rises 2 edges after column 15 sample with row=2, column=10, length=5; exactly one event.
2. Row 0 hit=1 for 2 samples then 0 → no event ever; dropped_count=0.
3. Rows 1 and 3 each high for 4 samples starting column 20, both end on the same sample → row 1 event (20,4), then row 3 event (20,4) on the next cycle; event_ready held 1.
4. event_ready=0; row 0 produces 10 runs of length 3 separated by single 0 samples → 9 events held, dropped_count=1, overflow=1. Then event_ready=1 → 9 events drain in order with columns 0,4,8,…,32, then event_valid=0.
5. hit_valid toggling every other cycle, row 4 high for 4 valid samples starting at column 254 → event column=254, length=4; column counter wraps to 2 after the run.
6. Reset asserted for 1 cycle while row 2 is mid-run and 3 events are queued → after the reset edge event_valid=0, overflow=0, dropped_count=0; next sample uses column 0; the interrupted run never appears.
